// File: rtl/cmp_run_controller.sv
// Run controller for an N-node Cardinal CMP: core reset hold, halt detection, drain wait, then a dump request stream.
// Optional watchdog timeout is built in when CMP_RUN_WATCHDOG_EN is defined.
module cmp_run_controller #(
  parameter int NUM_NODES    = 4,
  parameter int NODE_W       = 2,
  parameter int ADDR_W       = 8,
  parameter int RESET_CYCLES = 5,
  parameter int DRAIN_CYCLES = 23,
  parameter int DUMP_DEPTH   = 128,
  parameter int CNT_W        = 32
`ifdef CMP_RUN_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = 2000
`endif
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_NODES*32-1:0] node_inst_in,
  output logic                    core_reset,
  output logic                    running,
  output logic                    halted,
  output logic [CNT_W-1:0]        run_cycles,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic [NODE_W-1:0]       dump_node,
  output logic [ADDR_W-1:0]       dump_addr,
  output logic                    done
`ifdef CMP_RUN_WATCHDOG_EN
  , output logic                  timeout
`endif
);

  localparam int HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  // DRAIN always lasts at least one cycle, so a zero drain still enters DUMP on the next cycle
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int DRAIN_W    = (DRAIN_LAST > 0) ? $clog2(DRAIN_LAST + 1) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_END  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_LAST);
  localparam logic [NODE_W-1:0]  LAST_NODE = NODE_W'(NUM_NODES - 1);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DUMP_DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               all_zero;

  // Program completion: every node is fetching the NOP terminator in the same cycle
  assign all_zero = (node_inst_in == {(NUM_NODES*32){1'b0}});

  // Controller state machine with all outputs registered
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= HOLD;
      core_reset <= 1'b1;
      running    <= 1'b0;
      halted     <= 1'b0;
      run_cycles <= {CNT_W{1'b0}};
      dump_valid <= 1'b0;
      dump_node  <= {NODE_W{1'b0}};
      dump_addr  <= {ADDR_W{1'b0}};
      done       <= 1'b0;
      hold_cnt   <= {HOLD_W{1'b0}};
      drain_cnt  <= {DRAIN_W{1'b0}};
`ifdef CMP_RUN_WATCHDOG_EN
      timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_END) begin
            core_reset <= 1'b0;
            running    <= 1'b1;
            state      <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (all_zero) begin
            running <= 1'b0;
            halted  <= 1'b1;
            state   <= DRAIN;
`ifdef CMP_RUN_WATCHDOG_EN
          end else if (run_cycles >= CNT_W'(WATCHDOG_CYCLES)) begin
            running <= 1'b0;
            timeout <= 1'b1;
            state   <= DRAIN;
`endif
          end else if (run_cycles != CNT_MAX) begin
            run_cycles <= run_cycles + CNT_W'(1);
          end else begin
            run_cycles <= run_cycles;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            dump_valid <= 1'b1;
            state      <= DUMP;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DUMP: begin
          // Address-major walk: step the node first, wrap to the next address
          if (dump_valid && dump_ready) begin
            if (dump_node == LAST_NODE) begin
              if (dump_addr == LAST_ADDR) begin
                dump_valid <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end else begin
                dump_node <= {NODE_W{1'b0}};
                dump_addr <= dump_addr + ADDR_W'(1);
              end
            end else begin
              dump_node <= dump_node + NODE_W'(1);
            end
          end else begin
            dump_node <= dump_node;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_run_controller.sv
// Scoreboard bench for cmp_run_controller: a default-parameter instance plus a small corner-parameter instance.
module tb_cmp_run_controller;

  localparam int N  = 4;
  localparam int RC = 5;
  localparam int DC = 23;
  localparam int DD = 128;

  logic         clk;
  logic         rst;
  logic [127:0] inst;
  logic         core_reset, running, halted, dump_valid, dump_ready, done;
  logic [31:0]  run_cycles;
  logic [1:0]   dump_node;
  logic [7:0]   dump_addr;

  logic         rst2;
  logic [95:0]  inst2;
  logic         core_reset2, running2, halted2, valid2, ready2, done2;
  logic [31:0]  run_cycles2;
  logic [1:0]   node2;
  logic [7:0]   addr2;
`ifdef CMP_RUN_WATCHDOG_EN
  logic         timeout, timeout2;
`endif

  int        n_checks;
  int        n_fail;
  int        ready_mode;
  int        ready_cyc;
  logic      expect_done;
  logic [9:0] sb[$];

  cmp_run_controller #(
    .NUM_NODES(4), .NODE_W(2), .ADDR_W(8), .RESET_CYCLES(5),
    .DRAIN_CYCLES(23), .DUMP_DEPTH(128), .CNT_W(32)
  ) u_dut (
    .CLK(clk), .RESET(rst), .node_inst_in(inst),
    .core_reset(core_reset), .running(running), .halted(halted),
    .run_cycles(run_cycles), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_node(dump_node), .dump_addr(dump_addr), .done(done)
`ifdef CMP_RUN_WATCHDOG_EN
    , .timeout(timeout)
`endif
  );

  cmp_run_controller #(
    .NUM_NODES(3), .NODE_W(2), .ADDR_W(8), .RESET_CYCLES(5),
    .DRAIN_CYCLES(0), .DUMP_DEPTH(1), .CNT_W(32)
`ifdef CMP_RUN_WATCHDOG_EN
    , .WATCHDOG_CYCLES(10)
`endif
  ) u_corner (
    .CLK(clk), .RESET(rst2), .node_inst_in(inst2),
    .core_reset(core_reset2), .running(running2), .halted(halted2),
    .run_cycles(run_cycles2), .dump_valid(valid2), .dump_ready(ready2),
    .dump_node(node2), .dump_addr(addr2), .done(done2)
`ifdef CMP_RUN_WATCHDOG_EN
    , .timeout(timeout2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Busy pattern: never all-zero; partial=1 leaves exactly one node nonzero
  function automatic logic [127:0] gen_busy(input bit partial);
    logic [127:0] v;
    int keep;
    keep = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) v[32*k +: 32] = partial ? 32'h0 : $urandom;
    if (v[32*keep +: 32] == 32'h0) v[32*keep +: 32] = 32'h0000_0013;
    return v;
  endfunction

  task automatic fill_queue();
    sb.delete();
    for (int a = 0; a < DD; a++)
      for (int n = 0; n < N; n++) sb.push_back({2'(n), 8'(a)});
  endtask

  // Reset, hold, a run of 'busy' non-terminating cycles, halt, and the drain interval
  task automatic start_run(input int busy);
    rst  = 1'b1;
    inst = 128'h0;
    step(); step(); step();
    check("reset_core_reset", core_reset, 1);
    check("reset_running", running, 0);
    check("reset_halted", halted, 0);
    check("reset_run_cycles", run_cycles, 0);
    check("reset_dump_valid", dump_valid, 0);
    check("reset_done", done, 0);
    fill_queue();
    rst = 1'b0;
    for (int k = 1; k <= RC; k++) begin
      step();
      check("hold_core_reset", core_reset, (k < RC) ? 1 : 0);
      check("hold_running", running, (k >= RC) ? 1 : 0);
    end
    check("run_cycles_start", run_cycles, 0);
    for (int i = 0; i < busy; i++) begin
      inst = gen_busy(i % 5 == 2);
      step();
    end
    check("run_cycles_count", run_cycles, busy);
    check("no_early_halt", halted, 0);
    check("still_running", running, 1);
    inst = 128'h0;
    step();
    check("halt_detect", halted, 1);
    check("halt_running", running, 0);
    check("halt_run_cycles", run_cycles, busy);
    for (int k = 1; k <= DC; k++) begin
      inst = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("drain_timing", dump_valid, (k >= DC) ? 1 : 0);
    end
    check("run_cycles_frozen", run_cycles, busy);
    check("core_reset_low_drain", core_reset, 0);
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (!done && t < limit) begin
      step();
      t++;
    end
    check("done_reached", done, 1);
    check("all_requests_accepted", sb.size(), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("done_holds", {done, dump_valid}, 2'b10);
    end
  endtask

  // Ready driver: changes only just after the active edge
  initial begin
    dump_ready = 1'b1;
    ready_cyc  = 0;
    forever begin
      @(posedge clk);
      #2;
      ready_cyc++;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = ((ready_cyc % 4) == 0) || ((ready_cyc % 4) == 3);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every presented request with the scoreboard head, pops on acceptance
  initial begin
    logic acc;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (expect_done && !rst) begin
        check("done_after_last", {done, dump_valid}, 2'b10);
        expect_done = 1'b0;
      end
      if (dump_valid === 1'b1 && !rst) begin
        if (sb.size() == 0) begin
          check("dump_extra_request", dump_valid, 0);
        end else begin
          check("dump_request", {dump_node, dump_addr}, sb[0]);
          acc = dump_ready;
        end
      end
      @(posedge clk);
      if (acc && !rst && sb.size() > 0) begin
        void'(sb.pop_front());
        if (sb.size() == 0) expect_done = 1'b1;
      end
    end
  end

  task automatic corner_test();
    int t;
    rst2  = 1'b1;
    inst2 = 96'h0;
    step(); step();
    check("corner_reset", {core_reset2, valid2, done2}, 3'b100);
    rst2 = 1'b0;
    for (int k = 1; k <= RC; k++) step();
    check("corner_running", running2, 1);
`ifdef CMP_RUN_WATCHDOG_EN
    t = 0;
    while (running2 && t < 40) begin
      inst2 = {$urandom | 32'h1, $urandom, $urandom};
      step();
      t++;
    end
    check("corner_timeout", timeout2, 1);
    check("corner_timeout_not_halted", halted2, 0);
    check("corner_timeout_run_cycles", run_cycles2, 10);
`else
    for (int i = 0; i < 3; i++) begin
      inst2 = {32'h0, 32'h0, $urandom | 32'h1};
      step();
    end
    inst2 = 96'h0;
    step();
    check("corner_halted", halted2, 1);
    check("corner_run_cycles", run_cycles2, 3);
`endif
    check("corner_drain_no_valid", valid2, 0);
    step();
    for (int n = 0; n < 3; n++) begin
      check("corner_dump_request", {valid2, node2, addr2}, {1'b1, 2'(n), 8'h00});
      step();
    end
    check("corner_done", {done2, valid2}, 2'b10);
  endtask

  initial begin
    int t;
    n_checks    = 0;
    n_fail      = 0;
    ready_mode  = 0;
    expect_done = 1'b0;
    rst         = 1'b1;
    inst        = 128'h0;
    rst2        = 1'b1;
    inst2       = 96'h0;
    ready2      = 1'b1;

    // Full dump with ready tied high
    start_run(40);
    wait_done(1500);

    // Backpressure, then reset while request (2,50) is pending
    ready_mode = 1;
    start_run($urandom_range(10, 60));
    t = 0;
    while (!(dump_valid && dump_node == 2'd2 && dump_addr == 8'd50) && t < 2000) begin
      step();
      t++;
    end
    check("reached_req_2_50", {dump_valid, dump_node, dump_addr}, {1'b1, 2'd2, 8'd50});
    rst = 1'b1;
    sb.delete();
    expect_done = 1'b0;
    step();
    check("midreset_dump_valid", dump_valid, 0);
    check("midreset_core_reset", core_reset, 1);
    check("midreset_run_cycles", run_cycles, 0);
    check("midreset_flags", {running, halted, done}, 3'b000);

    // Rerun with random ready: dump must restart at (0,0)
    ready_mode = 2;
    start_run($urandom_range(1, 30));
    wait_done(3000);

    corner_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_run_controller.md
Name: cmp_run_controller

Overview:
- Parametrised, synthesizable run controller for an N-node Cardinal CMP.
- Sequences the core reset hold, then detects program completion: all nodes fetching the NOP terminator 32'h00000000 in the same cycle.
- Counts run cycles, waits a fixed pipeline/NoC drain interval, then emits a valid/ready stream of data-memory dump requests covering every node.
- Sits beside cardinal_cmp at the top level; it replaces the fixed 4-node sequencing previously hand-written in simulation.

Parameters:
- NUM_NODES, 4, number of CMP nodes monitored (1..16)
- NODE_W, 2, width of dump_node; must satisfy 2^NODE_W >= NUM_NODES
- ADDR_W, 8, width of dump_addr
- RESET_CYCLES, 5, cycles core_reset stays high after RESET deasserts (>=1)
- DRAIN_CYCLES, 23, cycles waited after halt detection before dumping (>=0)
- DUMP_DEPTH, 128, locations dumped per node (1..2^ADDR_W)
- CNT_W, 32, width of run_cycles

Ports:
- CLK  input  1  system clock; all logic on posedge
- RESET  input  1  synchronous, active-high reset
- node_inst_in  input  NUM_NODES*32  instruction bus per node; node k occupies bits [32k:32k+31]
- core_reset  output  1  reset to cardinal_cmp and its cores
- running  output  1  high while in RUN
- halted  output  1  high from halt detection until RESET
- run_cycles  output  CNT_W  cycles spent in RUN
- dump_valid  output  1  dump request valid
- dump_ready  input  1  consumer accepts the request
- dump_node  output  NODE_W  node index of the current request
- dump_addr  output  ADDR_W  memory address of the current request
- done  output  1  all dump requests have been accepted

Behaviour:
- State register values: HOLD, RUN, DRAIN, DUMP, DONE. All outputs are registered.
- RESET=1 (at any time, including mid-dump):
  - Next state HOLD.
  - core_reset=1; running, halted, dump_valid and done = 0.
  - run_cycles=0; dump_node=0; dump_addr=0; hold counter and drain counter = 0.
- HOLD:
  - core_reset=1.
  - Counts cycles with RESET=0.
  - After exactly RESET_CYCLES such cycles: core_reset=0, running=1, state RUN.
  - core_reset therefore falls on the RESET_CYCLES-th posedge after RESET is sampled low.
- RUN:
  - Each cycle in which not all nodes show 32'h00000000: run_cycles increments by 1, saturating at all-ones (no wrap).
  - Cycle in which every node's 32-bit slice equals 0:
    - run_cycles does not increment (holds).
    - Next cycle: running=0, halted=1, state DRAIN.
  - Partial zeros (some nodes only) do not halt.
  - Halt is never detected in HOLD; buses are ignored there.
- DRAIN:
  - Waits DRAIN_CYCLES cycles, then enters DUMP.
  - DRAIN_CYCLES=0: DUMP is entered on the cycle after DRAIN is entered.
  - run_cycles frozen; core_reset stays 0 (cores keep running to flush).
- DUMP:
  - dump_valid=1 with {dump_node, dump_addr} starting at {0,0}.
  - Order is address-major, node-minor: (n0,a0), (n1,a0), … (nN-1,a0), (n0,a1), …
  - Advance only on dump_valid && dump_ready. Outputs hold stable while dump_ready=0.
  - After the accepted request (NUM_NODES-1, DUMP_DEPTH-1): dump_valid=0, done=1, state DONE.
  - Total accepted requests = NUM_NODES*DUMP_DEPTH.
- DONE: terminal; outputs hold until RESET.
- node_inst_in changes after halt detection are ignored.

Optional Feature:
- Macro: CMP_RUN_WATCHDOG_EN.
- Defined:
  - Adds parameter WATCHDOG_CYCLES (default 2000) and output timeout (1 bit, reset 0).
  - If run_cycles reaches WATCHDOG_CYCLES while in RUN: timeout=1 and the controller proceeds to DRAIN exactly as on halt, but halted stays 0.
  - timeout is sticky until RESET.
- Undefined: no port, no logic; RUN waits indefinitely for halt.

Test Plan:
1. Reset sequence (defaults): hold RESET 3 cycles, release → core_reset falls exactly 5 posedges later; running rises the same edge; run_cycles=0.
2. Halt detection: all four nodes drive nonzero for 40 RUN cycles, then all four zero → run_cycles=40, halted=1 next cycle; a single node at zero earlier does not halt.
3. Drain and full dump: after halt, with dump_ready tied 1 → dump_valid rises 23 cycles after DRAIN entry. Exactly 512 requests in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,127). done=1 the cycle after the last request.
4. Backpressure: toggle dump_ready 1,0,0,1… → each request is accepted once, with no skips or duplicates; dump_node/dump_addr stable while not ready.
5. Reset mid-dump: assert RESET at request (2,50) → next cycle dump_valid=0, core_reset=1, run_cycles=0; rerun restarts the dump at (0,0).
6. Parameter corner: NUM_NODES=3, NODE_W=2, DUMP_DEPTH=1, DRAIN_CYCLES=0 → 3 requests (0,0),(1,0),(2,0), DUMP entered the cycle after DRAIN. With CMP_RUN_WATCHDOG_EN and WATCHDOG_CYCLES=10, never halting → timeout=1, halted=0, dump proceeds.
